// File: rtl/pee_arb_pkg.sv
// Shared types and constants for the PEE port arbiter.
// The optional watchdog is selected in the top by PEE_ARB_WATCHDOG_EN.
package pee_arb_pkg;

  localparam int PEE_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DRAIN   = 2'd3
  } pee_arb_state_e;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_PEE_ERR = 2'd1;
  localparam logic [1:0] RSP_WDOG    = 2'd2;

  // Requester index to one-hot; callers truncate to their own width.
  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    idx_to_onehot = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/pee_rr_picker.sv
// Combinational round-robin priority encoder: the first asserted request
// strictly after `last`, wrapping modulo NUM_REQ.
module pee_rr_picker
  import pee_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int               w_cand;
  logic [IDX_W-1:0] w_sel;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = 0;
    w_sel  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = int'(last) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end else begin
        w_cand = w_cand;
      end
      w_sel = IDX_W'(w_cand);
      if (req[w_sel]) begin
        valid = 1'b1;
        idx   = w_sel;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/pee_arbiter.sv
// Round-robin arbiter/sequencer sharing the PEE CPU-side port between requesters.
// Define PEE_ARB_WATCHDOG_EN to add the hung-transaction watchdog and DRAIN state.
module pee_arbiter
  import pee_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [PEE_ADDR_W*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [31:0]                rsp_result,
  output logic [1:0]                 rsp_err,
  output logic                       pee_req,
  output logic [PEE_ADDR_W-1:0]      pee_code_addr,
  input  logic                       pee_ack,
  input  logic [31:0]                pee_result,
  input  logic                       pee_error,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (WDOG_CYCLES < 2)) begin : g_bad_cfg
    $error("pee_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES at least 2");
  end

  pee_arb_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_last, w_last_nxt;
  logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]      r_done, w_done_nxt;
  logic [31:0]             r_rsp_result, w_rsp_result_nxt;
  logic [1:0]              r_rsp_err, w_rsp_err_nxt;
  logic                    r_pee_req, w_pee_req_nxt;
  logic [PEE_ADDR_W-1:0]   r_pee_code_addr, w_pee_code_addr_nxt;
  logic                    r_busy;

  logic                    w_pick_valid;
  logic [IDX_W-1:0]        w_pick_idx;
  logic [NUM_REQ-1:0]      w_pick_onehot;
  logic [PEE_ADDR_W-1:0]   w_addr_sel;

`ifdef PEE_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES);
  logic [WDOG_W-1:0]       r_wdog, w_wdog_nxt;
`endif

  pee_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (req),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_pick_onehot = NUM_REQ'(idx_to_onehot(3'(w_pick_idx)));

  // Address slice of the requester being picked.
  always_comb begin
    w_addr_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_idx == IDX_W'(k)) begin
        w_addr_sel = req_addr[k*PEE_ADDR_W +: PEE_ADDR_W];
      end else begin
        w_addr_sel = w_addr_sel;
      end
    end
  end

  // Next-state and next-output logic; `grant` doubles as the owner record.
  always_comb begin
    w_state_nxt         = r_state;
    w_last_nxt          = r_last;
    w_grant_nxt         = r_grant;
    w_done_nxt          = '0;
    w_rsp_result_nxt    = r_rsp_result;
    w_rsp_err_nxt       = r_rsp_err;
    w_pee_req_nxt       = r_pee_req;
    w_pee_code_addr_nxt = r_pee_code_addr;
`ifdef PEE_ARB_WATCHDOG_EN
    w_wdog_nxt          = r_wdog;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt         = ST_ISSUE;
          w_last_nxt          = w_pick_idx;
          w_grant_nxt         = w_pick_onehot;
          w_pee_code_addr_nxt = w_addr_sel;
          w_pee_req_nxt       = 1'b1;
`ifdef PEE_ARB_WATCHDOG_EN
          w_wdog_nxt          = WDOG_W'(WDOG_CYCLES - 1);
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (pee_ack) begin
          w_state_nxt      = ST_RELEASE;
          w_rsp_result_nxt = pee_result;
          w_rsp_err_nxt    = pee_error ? RSP_PEE_ERR : RSP_OK;
          w_pee_req_nxt    = 1'b0;
          w_done_nxt       = r_grant;
`ifdef PEE_ARB_WATCHDOG_EN
        end else if (r_wdog == '0) begin
          // The late ack from the PEE is still owed; absorb it in DRAIN.
          w_state_nxt      = ST_DRAIN;
          w_rsp_result_nxt = 32'd0;
          w_rsp_err_nxt    = RSP_WDOG;
          w_pee_req_nxt    = 1'b0;
          w_done_nxt       = r_grant;
        end else begin
          w_wdog_nxt = r_wdog - WDOG_W'(1);
        end
`else
        end else begin
          w_state_nxt = ST_ISSUE;
        end
`endif
      end
      ST_RELEASE: begin
        if (!pee_ack) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_DRAIN: begin
`ifdef PEE_ARB_WATCHDOG_EN
        if (pee_ack) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
`else
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
`endif
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_grant_nxt   = '0;
        w_pee_req_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_last          <= IDX_W'(NUM_REQ - 1);
      r_grant         <= '0;
      r_done          <= '0;
      r_rsp_result    <= 32'd0;
      r_rsp_err       <= RSP_OK;
      r_pee_req       <= 1'b0;
      r_pee_code_addr <= '0;
      r_busy          <= 1'b0;
`ifdef PEE_ARB_WATCHDOG_EN
      r_wdog          <= '0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_last          <= w_last_nxt;
      r_grant         <= w_grant_nxt;
      r_done          <= w_done_nxt;
      r_rsp_result    <= w_rsp_result_nxt;
      r_rsp_err       <= w_rsp_err_nxt;
      r_pee_req       <= w_pee_req_nxt;
      r_pee_code_addr <= w_pee_code_addr_nxt;
      r_busy          <= (w_state_nxt != ST_IDLE);
`ifdef PEE_ARB_WATCHDOG_EN
      r_wdog          <= w_wdog_nxt;
`endif
    end
  end

  assign grant         = r_grant;
  assign done          = r_done;
  assign rsp_result    = r_rsp_result;
  assign rsp_err       = r_rsp_err;
  assign pee_req       = r_pee_req;
  assign pee_code_addr = r_pee_code_addr;
  assign busy          = r_busy;

endmodule

// File: tb/tb_pee_arbiter.sv
// Directed bench for pee_arbiter: a transaction-level reference model compared
// every cycle, plus hand-computed expectations per scenario.
module tb_pee_arbiter;

  localparam int N  = 4;
  localparam int WD = 16;
`ifdef PEE_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_addr;
  logic [N-1:0]    grant, done;
  logic [31:0]     rsp_result;
  logic [1:0]      rsp_err;
  logic            pee_req;
  logic [31:0]     pee_code_addr;
  logic            pee_ack;
  logic [31:0]     pee_result;
  logic            pee_error;
  logic            busy;

  always #5 clk = ~clk;

  pee_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .grant(grant), .done(done), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .pee_req(pee_req), .pee_code_addr(pee_code_addr), .pee_ack(pee_ack),
    .pee_result(pee_result), .pee_error(pee_error), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- PEE responder ----------------
  int          pee_lat = 5;
  logic [31:0] pee_res = 32'd0;
  logic        pee_err_v = 1'b0;
  bit          pee_manual = 1'b0;
  int          pee_cnt = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!pee_manual) begin
      if (!pee_req) begin
        pee_ack = 1'b0;
        pee_cnt = 0;
      end else if (!pee_ack) begin
        pee_cnt++;
        if (pee_cnt >= pee_lat) begin
          pee_ack    = 1'b1;
          pee_result = pee_res;
          pee_error  = pee_err_v;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Transaction view: phase 0 = free, 1 = waiting for ack, 2 = waiting for ack to
  // drop, 3 = discarding an aborted transaction's late ack.
  int          m_phase = 0;
  int          m_last = N - 1;
  int          m_owner = 0;
  int          m_left = 0;
  bit          m_valid = 1'b0;
  int          pick;
  logic [N-1:0] exp_grant, exp_done;
  logic [31:0] exp_result, exp_addr;
  logic [1:0]  exp_err;
  logic        exp_pee_req, exp_busy;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1; m_phase = 0; m_last = N - 1;
      exp_grant = '0; exp_done = '0; exp_result = 32'd0; exp_addr = 32'd0;
      exp_err = 2'd0; exp_pee_req = 1'b0; exp_busy = 1'b0;
    end else if (m_valid) begin
      exp_done = '0;
      if (m_phase == 0) begin
        pick = -1;
        for (int j = 1; j <= N; j++) begin
          if (pick < 0 && req[(m_last + j) % N]) pick = (m_last + j) % N;
        end
        if (pick >= 0) begin
          m_owner = pick; m_last = pick;
          exp_grant = '0; exp_grant[pick] = 1'b1;
          exp_addr = req_addr[pick*32 +: 32];
          exp_pee_req = 1'b1; exp_busy = 1'b1;
          m_left = WD - 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (pee_ack) begin
          exp_result = pee_result; exp_err = pee_error ? 2'd1 : 2'd0;
          exp_pee_req = 1'b0; exp_done[m_owner] = 1'b1; m_phase = 2;
        end else if (WD_EN && m_left == 0) begin
          exp_result = 32'd0; exp_err = 2'd2;
          exp_pee_req = 1'b0; exp_done[m_owner] = 1'b1; m_phase = 3;
        end else begin
          m_left--;
        end
      end else if (m_phase == 2) begin
        if (!pee_ack) begin
          m_phase = 0; exp_grant = '0; exp_busy = 1'b0;
        end
      end else begin
        if (pee_ack) m_phase = 2;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("grant",         32'(grant),         32'(exp_grant));
      chk("done",          32'(done),          32'(exp_done));
      chk("rsp_result",    rsp_result,         exp_result);
      chk("rsp_err",       32'(rsp_err),       32'(exp_err));
      chk("pee_req",       32'(pee_req),       32'(exp_pee_req));
      chk("pee_code_addr", pee_code_addr,      exp_addr);
      chk("busy",          32'(busy),          32'(exp_busy));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(output logic [N-1:0] d);
    d = '0;
    for (int k = 0; k < 300; k++) begin
      cyc(1);
      if (done != '0) begin
        d = done;
        break;
      end
    end
    checks++;
    if (d == '0) begin
      errors++;
      $display("FAIL done_timeout: no done pulse within 300 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  logic [N-1:0] dn;
  int           order[$];
  int           exp_order[5] = '{0, 1, 2, 3, 0};
  int           gap;

  initial begin
    rst = 1'b1; req = '0; req_addr = '0;
    pee_ack = 1'b0; pee_result = 32'd0; pee_error = 1'b0;
    cyc(2);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_grant",   32'(grant),   32'd0);
    chk("reset_pee_req", 32'(pee_req), 32'd0);
    rst = 1'b0;

    // Single request from requester 2.
    req_addr[2*32 +: 32] = 32'h0000_1234;
    pee_res = 32'h0000_CAFE; pee_err_v = 1'b0; pee_lat = 5;
    req = 4'b0100;
    cyc(1);
    chk("t1_grant",   32'(grant),    32'h4);
    chk("t1_addr",    pee_code_addr, 32'h0000_1234);
    chk("t1_pee_req", 32'(pee_req),  32'd1);
    wait_done(dn);
    chk("t1_done",    32'(dn),         32'h4);
    chk("t1_result",  rsp_result,      32'h0000_CAFE);
    chk("t1_err",     32'(rsp_err),    32'd0);
    cyc(1);
    req = '0;
    chk("t1_done_once", 32'(done), 32'd0);
    cyc(4);

    // Round-robin fairness with all requesters held.
    do_reset();
    for (int k = 0; k < N; k++) req_addr[k*32 +: 32] = 32'h0000_1000 + 32'(k);
    pee_lat = 3; pee_res = 32'h0000_00A5;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(dn);
      order.push_back(oh2i(dn));
    end
    cyc(1);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end
    cyc(4);

    // PEE error then a normal follow-up.
    do_reset();
    pee_res = 32'h0000_4002; pee_err_v = 1'b1;
    req = 4'b0010;
    wait_done(dn);
    chk("t3_done",   32'(dn),      32'h2);
    chk("t3_err",    32'(rsp_err), 32'd1);
    chk("t3_result", rsp_result,   32'h0000_4002);
    cyc(1);
    pee_res = 32'h0000_0055; pee_err_v = 1'b0;
    req = 4'b1000;
    wait_done(dn);
    chk("t3b_done",   32'(dn),      32'h8);
    chk("t3b_err",    32'(rsp_err), 32'd0);
    chk("t3b_result", rsp_result,   32'h0000_0055);
    cyc(1);
    req = '0;
    cyc(4);

    // Hung PEE: ack only at cycle 40, requester 1 queued behind requester 0.
    do_reset();
    pee_manual = 1'b1; pee_ack = 1'b0; pee_error = 1'b0;
    req = 4'b0011;                          // cycle 0
    cyc(16);
    chk("t4_c16_done", 32'(done), 32'd0);
    cyc(1);                                 // cycle 17
    chk("t4_c17_done", 32'(done),    WD_EN ? 32'h1 : 32'h0);
    chk("t4_c17_err",  32'(rsp_err), WD_EN ? 32'd2 : 32'd0);
    cyc(1);                                 // cycle 18
    if (WD_EN) req = 4'b0010;
    cyc(21);                                // cycle 39
    chk("t4_c39_pee_req", 32'(pee_req), WD_EN ? 32'd0 : 32'd1);
    cyc(1);                                 // cycle 40
    pee_ack = 1'b1; pee_result = 32'h0000_BEEF;
    cyc(1);                                 // cycle 41
    pee_ack = 1'b0;
    chk("t4_c41_done", 32'(done),  WD_EN ? 32'h0 : 32'h1);
    chk("t4_c41_res",  rsp_result, WD_EN ? 32'h0 : 32'h0000_BEEF);
    cyc(1);                                 // cycle 42
    req = 4'b0010;
    chk("t4_c42_pee_req", 32'(pee_req), 32'd0);
    cyc(1);                                 // cycle 43
    chk("t4_c43_pee_req", 32'(pee_req), 32'd1);
    chk("t4_c43_grant",   32'(grant),   32'h2);
    pee_lat = 3; pee_res = 32'h0000_0077; pee_cnt = 0; pee_manual = 1'b0;
    wait_done(dn);
    chk("t4_r1_done",   32'(dn),    32'h2);
    chk("t4_r1_result", rsp_result, 32'h0000_0077);
    cyc(1);
    req = '0;
    cyc(4);

    // Reset while a transaction is outstanding.
    pee_lat = 50;
    req = 4'b0100;
    cyc(3);
    chk("t5_pre_pee_req", 32'(pee_req), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("t5_pee_req", 32'(pee_req), 32'd0);
    chk("t5_grant",   32'(grant),   32'd0);
    chk("t5_busy",    32'(busy),    32'd0);
    rst = 1'b0;
    pee_lat = 3;
    req = 4'b1101;
    cyc(1);
    chk("t5_first_grant", 32'(grant), 32'h1);
    wait_done(dn);
    chk("t5_done", 32'(dn), 32'h1);
    cyc(1);
    req = '0;
    cyc(4);

    // Back-to-back from requester 0.
    pee_res = 32'h0000_0011;
    req = 4'b0001;
    wait_done(dn);
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      gap++;
      if (pee_req) break;
    end
    chk("t6_gap",     32'(gap),     32'd2);
    chk("t6_ack_low", 32'(pee_ack), 32'd0);
    wait_done(dn);
    chk("t6_done2", 32'(dn), 32'h1);
    cyc(1);
    req = '0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
